pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised fetch program-counter unit for the RISC-V core. Successor to the fixed 32-bit PC register plus +4 incrementer.
- Adds configurable width and reset vector, optional compressed (+2) stepping, stall/fetch handshake, and prioritised redirects (trap, mret, branch/jump).
- Adds misaligned-target detection and a small return-address stack (RAS).
- Sits between the control/execute stage and instruction-memory address port.

Parameters:
XLEN, 32, PC and address width in bits
RESET_VECTOR, 0, PC value loaded on reset
COMPRESSED, 0, 1 = allow 2-byte instruction steps and 2-byte-aligned targets
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fetch_ready  in  1  instruction memory accepts pc_out this cycle
stall  in  1  hold PC (pipeline hazard)
is_compressed  in  1  current instruction is 16-bit (ignored when COMPRESSED=0)
trap_valid  in  1  take trap
trap_vector  in  XLEN  trap handler address (mtvec)
mret_valid  in  1  return from trap
mepc  in  XLEN  trap return address
redirect_valid  in  1  branch taken / jump
redirect_target  in  XLEN  branch/jump target
call_valid  in  1  current instruction is a call; push return address
ret_valid  in  1  current instruction is a return; pop RAS
pc_out  out  XLEN  current fetch PC
pc_valid  out  1  pc_out is a valid fetch request
pc_seq  out  XLEN  pc_out + step (2 or 4), combinational
misaligned_err  out  1  one-cycle pulse: redirect target misaligned
misaligned_addr  out  XLEN  offending target, held until next error
ras_top  out  XLEN  top RAS entry (predicted return target)
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries

Behaviour:
- Reset (asynchronous, any cycle, including mid-redirect):
  - pc_out = RESET_VECTOR, pc_valid = 0, misaligned_err = 0, misaligned_addr = 0.
  - RAS pointer = 0, ras_empty = 1, ras_full = 0, ras_top = 0.
- pc_valid goes to 1 on the first clock after reset deasserts, then stays 1.
- Step: 2 if COMPRESSED=1 and is_compressed=1, else 4. pc_seq = pc_out + step, modulo 2^XLEN; wraps with no flag.
- Next-PC priority, evaluated each rising edge:
  1. trap_valid: pc_out <= trap_vector & ~3.
  2. mret_valid: pc_out <= mepc.
  3. redirect_valid and target aligned: pc_out <= redirect_target.
  4. redirect_valid and target misaligned: pc_out holds; misaligned_err = 1 next cycle; misaligned_addr <= redirect_target.
  5. stall = 1 or fetch_ready = 0: hold.
  6. Otherwise: pc_out <= pc_seq.
- Trap, mret and redirect are honoured regardless of stall/fetch_ready; they are never lost.
- Misaligned definition: bit0 = 1 always; bit1 = 1 when COMPRESSED=0.
- misaligned_err is a single-cycle pulse. Back-to-back misaligned redirects pulse on consecutive cycles.
- RAS is a circular stack; it only updates on cycles where the PC advances or redirects (not on stalls).
  - call_valid: push pc_seq.
  - ret_valid: pop.
  - Push when full: overwrites the oldest entry; pointer wraps; ras_full stays 1.
  - Pop when empty: ignored; ras_top stays 0.
  - call_valid and ret_valid together: replace top with pc_seq; depth unchanged.
  - trap_valid: RAS unchanged.
- ras_top is registered; it reflects state after the last update.
- Latency: every redirect is visible on pc_out exactly one cycle after assertion.

Decomposition:
- Shared package core_pkg:
  - XLEN default.
  - Step constants STEP_NORMAL = 4, STEP_COMP = 2.
  - pc_sel_e enum: TRAP, MRET, REDIRECT, HOLD, SEQ.
- Sub-module ras_stack (parameters XLEN, RAS_DEPTH): push, pop, push_data, top, empty, full.
- Next-PC select and misalignment check stay in pc_unit.

Test Plan:
- Reset release with fetch_ready=1, no events, XLEN=32, RESET_VECTOR=0 -> pc_out sequence 0, 4, 8, 0xC; pc_valid rises after the first edge.
- COMPRESSED=1, is_compressed pattern 1,0,1 from 0x100 -> pc_out 0x102, 0x106, 0x108.
- redirect_valid with target 0x2000 during stall=1 -> pc_out 0x2000 next cycle; target 0x2002 with COMPRESSED=0 -> misaligned_err one-cycle pulse, misaligned_addr=0x2002, PC held.
- trap_valid + redirect_valid + mret_valid in the same cycle, trap_vector=0x80000001 -> pc_out 0x80000000. Following cycle mret_valid, mepc=0x40 -> pc_out 0x40.
- RAS_DEPTH=4: five calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1, ras_top=0x54. Four pops give 0x44, 0x34, 0x24 with ras_empty=1 at the end; a fifth pop is ignored.
- PC=0xFFFFFFFC, no events -> pc_out wraps to 0; reset asserted mid-stream -> pc_out=RESET_VECTOR immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN_DEFAULT : default PC/address width
//   STEP_NORMAL  : byte step for a 32-bit instruction
//   STEP_COMP    : byte step for a 16-bit (compressed) instruction
//   pc_sel_e     : next-PC source, listed in priority order
package core_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int STEP_NORMAL  = 4;
    localparam int STEP_COMP    = 2;

    typedef enum logic [2:0] {
        TRAP,
        MRET,
        REDIRECT,
        HOLD,
        SEQ
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   clk, reset : clock, asynchronous active-high reset
//   push       : store push_data as the new top
//   pop        : drop the top entry (ignored when empty)
//   push_data  : value written by push
//   top        : registered top entry, 0 when empty
//   empty/full : depth is 0 / RAS_DEPTH
// push and pop together replace the top entry. Pushing when full
// overwrites the oldest entry, because the write pointer wraps onto it.
module ras_stack import core_pkg::*; #(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(RAS_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [AW-1:0]   ptr_q, ptr_d;     // next free slot
    logic [AW:0]     cnt_q, cnt_d;     // live entries
    logic [XLEN-1:0] top_q, top_d;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   idx_m1, idx_m2;

    assign idx_m1 = ptr_q - AW'(1);
    assign idx_m2 = ptr_q - AW'(2);

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);
    assign top   = top_q;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        top_d  = top_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = idx_m1;
            top_d  = push_data;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            ptr_d  = ptr_q + AW'(1);
            top_d  = push_data;
            if (!full) begin
                cnt_d = cnt_q + ONE_C;
            end
        end else if (pop && !empty) begin
            ptr_d = idx_m1;
            cnt_d = cnt_q - ONE_C;
            // New top is the entry below the current one, if any remains.
            top_d = (cnt_q == ONE_C) ? '0 : mem_q[idx_m2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            top_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            if (wr_en) begin
                mem_q[wr_idx] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program-counter unit.
//   clk, reset            : clock, asynchronous active-high reset
//   fetch_ready, stall    : sequential advance only when ready and not stalled
//   is_compressed         : 16-bit instruction (2-byte step) when COMPRESSED=1
//   trap_valid/vector     : highest-priority redirect, low two bits cleared
//   mret_valid/mepc       : return-from-trap redirect
//   redirect_valid/target : branch/jump redirect, checked for alignment
//   call_valid/ret_valid  : push pc_seq / pop on the return-address stack
//   pc_out, pc_valid      : fetch request
//   pc_seq                : pc_out + step (combinational)
//   misaligned_err/addr   : one-cycle error pulse and last offending target
//   ras_top/empty/full    : return-address stack status
module pc_unit import core_pkg::*; #(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              COMPRESSED   = 1'b0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            is_compressed,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call_valid,
    input  logic            ret_valid,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_seq,
    output logic            misaligned_err,
    output logic [XLEN-1:0] misaligned_addr,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q;
    logic            err_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] step;
    logic            tgt_mis;
    logic            mis_take;
    logic            ras_upd;
    pc_sel_e         sel;

    assign step    = (COMPRESSED && is_compressed) ? XLEN'(STEP_COMP) : XLEN'(STEP_NORMAL);
    assign pc_seq  = pc_q + step;
    assign tgt_mis = redirect_target[0] || (!COMPRESSED && redirect_target[1]);

    // A misaligned redirect only counts if no trap/mret outranks it.
    assign mis_take = redirect_valid && tgt_mis && !trap_valid && !mret_valid;

    always_comb begin
        if (trap_valid) begin
            sel = TRAP;
        end else if (mret_valid) begin
            sel = MRET;
        end else if (redirect_valid && !tgt_mis) begin
            sel = REDIRECT;
        end else if (redirect_valid || stall || !fetch_ready || !pc_valid_q) begin
            // The first cycle after reset presents RESET_VECTOR before stepping.
            sel = HOLD;
        end else begin
            sel = SEQ;
        end
    end

    always_comb begin
        case (sel)
            TRAP:     pc_d = trap_vector & ~XLEN'(3);
            MRET:     pc_d = mepc;
            REDIRECT: pc_d = redirect_target;
            SEQ:      pc_d = pc_seq;
            default:  pc_d = pc_q;
        endcase
    end

    // The stack follows the PC: frozen on holds, stalls and traps.
    assign ras_upd = (sel == MRET) || (sel == REDIRECT) || (sel == SEQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
            err_q      <= mis_take;
            if (mis_take) begin
                addr_q <= redirect_target;
            end
        end
    end

    assign pc_out          = pc_q;
    assign pc_valid        = pc_valid_q;
    assign misaligned_err  = err_q;
    assign misaligned_addr = addr_q;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_upd && call_valid),
        .pop       (ras_upd && ret_valid),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule
